if_fetch: RTL and testbench

Instruction fetch stage for the pipelined core; produces the field bundle registered by the IF/ID pipeline register. Owns the PC, issues word reads to instruction memory over a single-outstanding req/rvalid interface, and splits each 16-bit word into format/opcode/register/immediate fields. Format 2'b11 (jump) instructions are two words; the second word is fetched as jmpLoc. Honours downstream stall and branch redirect/flush.

---
 rtl/if_pkg.sv | 46 ++++
 rtl/if_decode.sv | 27 ++
 rtl/if_fetch.sv | 150 +++++++++++++++
 tb/tb_if_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_WAIT_OP   = 3'd1,
        ST_FETCH_EXT = 3'd2,
        ST_WAIT_EXT  = 3'd3,
        ST_OUT       = 3'd4,
        ST_DRAIN     = 3'd5
    } if_state_t;

    localparam logic [1:0] c_FMT_JUMP_DEFAULT = 2'b11;

    // Bit positions of the instruction fields inside a 16-bit word
    localparam int c_FORMAT_LSB  = 14;
    localparam int c_OPCODE_LSB  = 10;
    localparam int c_REGD_LSB    = 7;
    localparam int c_REG1_LSB    = 4;
    localparam int c_REG2_LSB    = 1;
    localparam int c_IMM_LSB     = 1;
    localparam int c_IMMFLAG_BIT = 0;

    typedef struct packed {
        logic [1:0] format;
        logic [3:0] opcode;
        logic [2:0] regd;
        logic [2:0] reg1;
        logic [2:0] reg2;
        logic [2:0] imm;
        logic       imm_flag;
    } instr_fields_t;

    // Number of words occupied by an instruction of the given format
    function automatic logic [15:0] insn_words(input logic [1:0] fmt,
                                               input logic [1:0] fmt_jump);
        return (fmt == fmt_jump) ? 16'd2 : 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_decode.sv
`default_nettype none
// ============================================================================
// Module      : if_decode
// Description : Combinational split of a 16-bit instruction word into fields.
// Revision    : 1.0 - initial release
// ============================================================================
module if_decode
    import if_pkg::*;
(
    input  logic [15:0]   i_word,
    output instr_fields_t o_fields
);

    // reg2 and imm deliberately alias the same bits; immFlag picks one downstream
    always_comb begin
        o_fields          = '0;
        o_fields.format   = i_word[c_FORMAT_LSB +: 2];
        o_fields.opcode   = i_word[c_OPCODE_LSB +: 4];
        o_fields.regd     = i_word[c_REGD_LSB +: 3];
        o_fields.reg1     = i_word[c_REG1_LSB +: 3];
        o_fields.reg2     = i_word[c_REG2_LSB +: 3];
        o_fields.imm      = i_word[c_IMM_LSB +: 3];
        o_fields.imm_flag = i_word[c_IMMFLAG_BIT];
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction fetch stage with single-outstanding memory reads,
//               two-word jump support, stall hold and redirect/drain.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [1:0]  FMT_JUMP = c_FMT_JUMP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [15:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    output logic        valid_o,
    output logic [15:0] pc_o,
    output logic [1:0]  format_o,
    output logic [3:0]  opcode_o,
    output logic [2:0]  regD_o,
    output logic [2:0]  reg1_o,
    output logic [2:0]  reg2_o,
    output logic [2:0]  imm_o,
    output logic        immFlag_o,
    output logic [15:0] jmpLoc_o
);

    if_state_t     r_state;
    if_state_t     w_state_nxt;
    logic [15:0]   r_pc;
    logic [15:0]   w_pc_nxt;
    instr_fields_t r_fields;
    instr_fields_t w_fields_nxt;
    instr_fields_t w_dec;
    logic [15:0]   r_pc_out;
    logic [15:0]   w_pc_out_nxt;
    logic [15:0]   r_jmp_loc;
    logic [15:0]   w_jmp_loc_nxt;
    logic          w_outstanding;

    if_decode u_decode (
        .i_word   (imem_rdata_i),
        .o_fields (w_dec)
    );

    // A request is in flight and its response is not arriving this cycle
    always_comb begin
        w_outstanding = 1'b0;
        case (r_state)
            ST_FETCH, ST_FETCH_EXT:           w_outstanding = 1'b1;
            ST_WAIT_OP, ST_WAIT_EXT, ST_DRAIN: w_outstanding = !imem_rvalid_i;
            default:                          w_outstanding = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_fields_nxt  = r_fields;
        w_pc_out_nxt  = r_pc_out;
        w_jmp_loc_nxt = r_jmp_loc;

        case (r_state)
            ST_FETCH: begin
                w_state_nxt = ST_WAIT_OP;
            end
            ST_WAIT_OP: begin
                if (imem_rvalid_i) begin
                    w_fields_nxt  = w_dec;
                    w_pc_out_nxt  = r_pc;
                    w_jmp_loc_nxt = 16'h0000;
                    w_state_nxt   = (w_dec.format == FMT_JUMP) ? ST_FETCH_EXT : ST_OUT;
                end
            end
            ST_FETCH_EXT: begin
                w_state_nxt = ST_WAIT_EXT;
            end
            ST_WAIT_EXT: begin
                if (imem_rvalid_i) begin
                    w_jmp_loc_nxt = imem_rdata_i;
                    w_state_nxt   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (!stall_i) begin
                    w_pc_nxt    = r_pc + insn_words(r_fields.format, FMT_JUMP);
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid_i) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase

        // Redirect overrides everything; a stale response still owed by memory
        // must be swallowed in DRAIN before the next request goes out.
        if (redirect_i) begin
            w_pc_nxt      = redirect_pc_i;
            w_fields_nxt  = r_fields;
            w_pc_out_nxt  = r_pc_out;
            w_jmp_loc_nxt = r_jmp_loc;
            w_state_nxt   = w_outstanding ? ST_DRAIN : ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_fields  <= '0;
            r_pc_out  <= 16'h0000;
            r_jmp_loc <= 16'h0000;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_fields  <= w_fields_nxt;
            r_pc_out  <= w_pc_out_nxt;
            r_jmp_loc <= w_jmp_loc_nxt;
        end
    end

    // Requests are suppressed while rst is held since memory is being reset too
    assign imem_req_o  = !rst && ((r_state == ST_FETCH) || (r_state == ST_FETCH_EXT));
    assign imem_addr_o = (r_state == ST_FETCH_EXT) ? (r_pc + 16'd1) : r_pc;
    assign valid_o     = (r_state == ST_OUT);

    assign pc_o      = r_pc_out;
    assign format_o  = r_fields.format;
    assign opcode_o  = r_fields.opcode;
    assign regD_o    = r_fields.regd;
    assign reg1_o    = r_fields.reg1;
    assign reg2_o    = r_fields.reg2;
    assign imm_o     = r_fields.imm;
    assign immFlag_o = r_fields.imm_flag;
    assign jmpLoc_o  = r_jmp_loc;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch: memory with random latency,
//               reference program model, directed and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    localparam logic [15:0] c_RESET_PC = 16'h0000;
    localparam logic [1:0]  c_FMT_JUMP = 2'b11;
    localparam int          c_TIMEOUT  = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [15:0] imem_rdata_i  = 16'h0000;
    logic        stall_i       = 1'b0;
    logic        redirect_i    = 1'b0;
    logic [15:0] redirect_pc_i = 16'h0000;
    logic        valid_o;
    logic [15:0] pc_o;
    logic [1:0]  format_o;
    logic [3:0]  opcode_o;
    logic [2:0]  regD_o;
    logic [2:0]  reg1_o;
    logic [2:0]  reg2_o;
    logic [2:0]  imm_o;
    logic        immFlag_o;
    logic [15:0] jmpLoc_o;

    if_fetch #(
        .RESET_PC (c_RESET_PC),
        .FMT_JUMP (c_FMT_JUMP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .format_o      (format_o),
        .opcode_o      (opcode_o),
        .regD_o        (regD_o),
        .reg1_o        (reg1_o),
        .reg2_o        (reg2_o),
        .imm_o         (imm_o),
        .immFlag_o     (immFlag_o),
        .jmpLoc_o      (jmpLoc_o)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];

    int total = 0;
    int bad   = 0;

    // Reference model: the program counter of the next instruction to present
    logic [15:0] exp_pc;
    int          nreq;
    int          mem_cnt;
    logic [15:0] mem_addr;
    int          lat_min = 1;
    int          lat_max = 1;
    int          idle;
    logic        prev_valid, prev_take, prev_hold, prev_redirect;
    logic [63:0] snap;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_jump(input logic [15:0] a);
        logic [15:0] w;
        w = mem[a];
        return w[15:14] == c_FMT_JUMP;
    endfunction

    function automatic logic [63:0] bundle();
        return {13'd0, pc_o, jmpLoc_o, format_o, opcode_o, regD_o, reg1_o, reg2_o, imm_o, immFlag_o};
    endfunction

    // One cycle of memory, monitoring and model update; called just after a negedge
    task automatic tick_body(input logic st, input logic rd, input logic [15:0] rpc);
        logic        resp_now;
        logic [15:0] w;
        logic [15:0] ea;
        logic [15:0] nx;
        int          limit;

        resp_now      = 1'b0;
        imem_rvalid_i = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                resp_now      = 1'b1;
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem[mem_addr];
            end
        end

        if (imem_req_o) begin
            check_eq("req_while_outstanding", {63'd0, (mem_cnt != 0) || resp_now}, 64'd0);
            limit = is_jump(exp_pc) ? 2 : 1;
            check_eq("req_count_ok", {63'd0, nreq < limit}, 64'd1);
            ea = exp_pc + 16'(nreq);
            check_eq("req_addr", {48'd0, imem_addr_o}, {48'd0, ea});
            nreq++;
            mem_cnt  = int'($urandom_range(lat_max, lat_min));
            mem_addr = imem_addr_o;
        end

        if (prev_take || prev_redirect)
            check_eq("valid_dropped", {63'd0, valid_o}, 64'd0);
        if (prev_valid && (prev_take || prev_redirect))
            check_eq("req_after_out", {63'd0, imem_req_o}, 64'd1);
        if (prev_hold) begin
            check_eq("valid_held", {63'd0, valid_o}, 64'd1);
            check_eq("hold_stable", bundle(), snap);
        end

        if (valid_o) begin
            idle = 0;
            w    = mem[exp_pc];
            nx   = exp_pc + 16'd1;
            check_eq("pc_o",      {48'd0, pc_o},      {48'd0, exp_pc});
            check_eq("format_o",  {62'd0, format_o},  {62'd0, w[15:14]});
            check_eq("opcode_o",  {60'd0, opcode_o},  {60'd0, w[13:10]});
            check_eq("regD_o",    {61'd0, regD_o},    {61'd0, w[9:7]});
            check_eq("reg1_o",    {61'd0, reg1_o},    {61'd0, w[6:4]});
            check_eq("reg2_o",    {61'd0, reg2_o},    {61'd0, w[3:1]});
            check_eq("imm_o",     {61'd0, imm_o},     {61'd0, w[3:1]});
            check_eq("immFlag_o", {63'd0, immFlag_o}, {63'd0, w[0]});
            check_eq("jmpLoc_o",  {48'd0, jmpLoc_o},  {48'd0, (is_jump(exp_pc) ? mem[nx] : 16'h0000)});
            check_eq("no_req_in_out", {63'd0, imem_req_o}, 64'd0);
        end else begin
            idle++;
            if (idle > c_TIMEOUT) begin
                check_eq("progress_timeout", 64'(idle), 64'd0);
                idle = 0;
            end
        end

        prev_valid    = valid_o;
        prev_take     = valid_o && !st && !rd;
        prev_hold     = valid_o && st && !rd;
        prev_redirect = rd;
        snap          = bundle();
        if (prev_take) begin
            exp_pc = exp_pc + (is_jump(exp_pc) ? 16'd2 : 16'd1);
            nreq   = 0;
        end
        if (rd) begin
            exp_pc = rpc;
            nreq   = 0;
            idle   = 0;
        end

        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
    endtask

    task automatic cycle(input logic st, input logic rd, input logic [15:0] rpc);
        @(negedge clk);
        #1;
        tick_body(st, rd, rpc);
    endtask

    task automatic run_until_valid(input logic st);
        for (int k = 0; k < 50; k++) begin
            cycle(st, 1'b0, 16'h0000);
            if (valid_o) break;
        end
        check_eq("wait_valid", {63'd0, valid_o}, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        mem_cnt       = 0;
        @(negedge clk);
        #1;
        check_eq("rst_valid",  {63'd0, valid_o},    64'd0);
        check_eq("rst_req",    {63'd0, imem_req_o}, 64'd0);
        check_eq("rst_addr",   {48'd0, imem_addr_o}, {48'd0, c_RESET_PC});
        check_eq("rst_bundle", bundle(), 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        exp_pc        = c_RESET_PC;
        nreq          = 0;
        idle          = 0;
        prev_valid    = 1'b0;
        prev_take     = 1'b0;
        prev_hold     = 1'b0;
        prev_redirect = 1'b0;
        tick_body(1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rpc;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mem[16'h0000] = 16'h4A5B;
        mem[16'h0010] = 16'hC000;
        mem[16'h0011] = 16'hBEEF;
        mem[16'hFFFF] = 16'h1234;

        // Single-word instruction at reset PC with 1-cycle memory
        lat_min = 1;
        lat_max = 1;
        do_reset();
        cycle(1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000);
        check_eq("t1_latency", {63'd0, valid_o}, 64'd1);
        check_eq("t1_format",  {62'd0, format_o}, 64'h1);
        check_eq("t1_opcode",  {60'd0, opcode_o}, 64'h2);
        check_eq("t1_regD",    {61'd0, regD_o},   64'h4);
        check_eq("t1_reg1",    {61'd0, reg1_o},   64'h5);
        check_eq("t1_reg2",    {61'd0, reg2_o},   64'h5);
        check_eq("t1_imm",     {61'd0, imm_o},    64'h5);
        check_eq("t1_immFlag", {63'd0, immFlag_o}, 64'h1);
        check_eq("t1_pc",      {48'd0, pc_o},     64'h0);
        check_eq("t1_jmpLoc",  {48'd0, jmpLoc_o}, 64'h0);
        cycle(1'b0, 1'b0, 16'h0000);
        check_eq("t1_next_addr", {47'd0, imem_req_o, imem_addr_o}, {47'd0, 1'b1, 16'h0001});

        // Two-word jump at 0x0010
        cycle(1'b0, 1'b1, 16'h0010);
        run_until_valid(1'b0);
        check_eq("t2_pc",     {48'd0, pc_o},     64'h0010);
        check_eq("t2_format", {62'd0, format_o}, 64'h3);
        check_eq("t2_jmpLoc", {48'd0, jmpLoc_o}, 64'hBEEF);
        cycle(1'b0, 1'b0, 16'h0000);
        check_eq("t2_next_addr", {47'd0, imem_req_o, imem_addr_o}, {47'd0, 1'b1, 16'h0012});

        // Stall hold for five cycles, then release
        run_until_valid(1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000);
        check_eq("t3_refetch", {63'd0, imem_req_o}, 64'd1);

        // Redirect while waiting on a slow memory
        lat_min = 3;
        lat_max = 3;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b0, 16'h0000);
            if (imem_req_o) break;
        end
        cycle(1'b0, 1'b1, 16'h0200);
        run_until_valid(1'b0);
        check_eq("t4_pc", {48'd0, pc_o}, 64'h0200);

        // Redirect together with stall while presenting
        lat_min = 1;
        lat_max = 1;
        run_until_valid(1'b1);
        cycle(1'b1, 1'b1, 16'h0300);
        cycle(1'b0, 1'b0, 16'h0000);
        check_eq("t5_valid", {63'd0, valid_o}, 64'd0);
        check_eq("t5_req",   {47'd0, imem_req_o, imem_addr_o}, {47'd0, 1'b1, 16'h0300});

        // PC wrap, single-word then jump at 0xFFFF
        cycle(1'b0, 1'b1, 16'hFFFF);
        run_until_valid(1'b0);
        check_eq("t6_pc", {48'd0, pc_o}, 64'hFFFF);
        cycle(1'b0, 1'b0, 16'h0000);
        check_eq("t6_wrap_addr", {47'd0, imem_req_o, imem_addr_o}, {47'd0, 1'b1, 16'h0000});
        mem[16'hFFFF] = 16'hC123;
        cycle(1'b0, 1'b1, 16'hFFFF);
        run_until_valid(1'b0);
        check_eq("t6_jmpLoc", {48'd0, jmpLoc_o}, 64'h4A5B);
        cycle(1'b0, 1'b0, 16'h0000);
        check_eq("t6_after_jump", {47'd0, imem_req_o, imem_addr_o}, {47'd0, 1'b1, 16'h0001});

        // Randomized traffic with variable latency, stalls and redirects
        lat_min = 1;
        lat_max = 3;
        for (int i = 0; i < 2000; i++) begin
            logic st;
            logic rd;
            if (i == 1000) do_reset();
            st = ($urandom % 10) < 3;
            rd = ($urandom % 25) == 0;
            case ($urandom % 4)
                0:       rpc = 16'hFFFF;
                1:       rpc = 16'hFFFE;
                default: rpc = 16'($urandom);
            endcase
            cycle(st, rd, rd ? rpc : 16'h0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
